// File: rtl/wrr_burst_scheduler_pkg.sv
// Shared types and helpers for the weighted round-robin burst scheduler.
// The rotating-priority search is kept here so other arbiters can reuse it.
package wrr_pkg;

    localparam int unsigned WRR_MAX_N = 32;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    typedef enum logic [0:0] {
        IDLE  = ST_IDLE,
        BURST = ST_BURST
    } wrr_state_e;

    typedef struct packed {
        logic        found;
        logic [31:0] idx;
    } pick_t;

    // First set bit of req[n-1:0] at or after start, wrapping modulo n.
    function automatic pick_t rr_first(
        input logic [WRR_MAX_N-1:0] req,
        input int unsigned          n,
        input int unsigned          start
    );
        pick_t       res;
        int unsigned j;
        res = '0;
        for (int unsigned k = 0; k < WRR_MAX_N; k++) begin
            j = start + k;
            // start < n, so a single subtract wraps; works for any n, not just powers of two
            if (j >= n) begin
                j = j - n;
            end
            if ((k < n) && !res.found && req[j[4:0]]) begin
                res.found = 1'b1;
                res.idx   = j;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/wrr_burst_scheduler_rr_pick.sv
// Combinational rotating-priority picker: selects the first requester
// at or after ptr, wrapping modulo N.
module rr_pick
    import wrr_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] sel,
    output logic          found
);

    logic [WRR_MAX_N-1:0] req_ext;
    pick_t                pick;

    generate
        for (genvar gi = 0; gi < WRR_MAX_N; gi++) begin : g_ext
            if (gi < N) begin : g_live
                assign req_ext[gi] = req[gi];
            end else begin : g_pad
                assign req_ext[gi] = 1'b0;
            end
        end
    endgenerate

    always_comb begin
        pick  = rr_first(req_ext, N, 32'(ptr));
        sel   = IW'(pick.idx);
        found = pick.found;
    end

endmodule

// File: rtl/wrr_burst_scheduler.sv
// Weighted round-robin scheduler sharing one valid/ready port between N
// burst requesters; the grant is locked for up to weight[i] whole bursts.
module wrr_burst_scheduler
    import wrr_pkg::*;
#(
    parameter int N  = 4,
    parameter int WW = 4,
    parameter int IW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [N-1:0]    req_valid,
    input  logic [N-1:0]    req_last,
    output logic [N-1:0]    req_ready,
    input  logic [N*WW-1:0] weight,
    input  logic            out_ready,
    output logic            out_valid,
    output logic            out_last,
    output logic [N-1:0]    grant,
    output logic [IW-1:0]   grant_idx,
    output logic            busy
);

    wrr_state_e    state_reg;
    logic [IW-1:0] ptr_reg;
    logic [IW-1:0] grant_idx_reg;
    logic [N-1:0]  grant_reg;
    logic [WW-1:0] credit_reg;
    logic          mid_reg;

    logic [IW-1:0] pick_sel;
    logic          pick_found;
    logic [N-1:0]  pick_onehot;
    logic [WW-1:0] weight_arr [N];
    logic [WW-1:0] credit_load;
    logic [IW-1:0] ptr_next;

    logic          busy_int;
    logic          s_valid;
    logic          s_last;
    logic          beat;
    logic          last_beat;
    logic          idle_boundary;
    logic          release_now;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req   (req_valid),
        .ptr   (ptr_reg),
        .sel   (pick_sel),
        .found (pick_found)
    );

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lane
            assign weight_arr[gi]  = weight[gi*WW +: WW];
            assign pick_onehot[gi] = (pick_sel == IW'(gi));
        end
    endgenerate

    // A zero quota still grants one burst so a requester is never starved by its own weight
    assign credit_load = (weight_arr[pick_sel] == '0) ? WW'(1) : weight_arr[pick_sel];

    assign ptr_next = (grant_idx_reg == IW'(N-1)) ? '0 : grant_idx_reg + IW'(1);

    assign busy_int  = (state_reg == BURST);
    assign s_valid   = req_valid[grant_idx_reg];
    assign s_last    = req_last[grant_idx_reg];

    assign out_valid = busy_int & s_valid;
    assign out_last  = busy_int & s_last;
    assign req_ready = grant_reg & {N{out_ready}};

    assign beat      = out_valid & out_ready;
    assign last_beat = beat & s_last;

    // Between bursts a silent grantee gives up the port at once rather than holding it idle
    assign idle_boundary = busy_int & ~mid_reg & ~s_valid;
    assign release_now   = (last_beat & (credit_reg <= WW'(1))) | idle_boundary;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            grant_reg     <= '0;
            grant_idx_reg <= '0;
            credit_reg    <= '0;
            mid_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pick_found) begin
                        state_reg     <= BURST;
                        grant_reg     <= pick_onehot;
                        grant_idx_reg <= pick_sel;
                        credit_reg    <= credit_load;
                        mid_reg       <= 1'b0;
                    end
                end
                BURST: begin
                    if (release_now) begin
                        state_reg     <= IDLE;
                        grant_reg     <= '0;
                        grant_idx_reg <= '0;
                        credit_reg    <= '0;
                        mid_reg       <= 1'b0;
                        ptr_reg       <= ptr_next;
                    end else if (beat) begin
                        if (s_last) begin
                            credit_reg <= credit_reg - WW'(1);
                            mid_reg    <= 1'b0;
                        end else begin
                            mid_reg    <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign grant     = grant_reg;
    assign grant_idx = grant_idx_reg;
    assign busy      = busy_int;

endmodule

// File: tb/tb_wrr_burst_scheduler.sv
// Self-checking bench for wrr_burst_scheduler: cycle vector table plus
// scoreboarded multi-burst sequences and a reset-mid-burst sequence.
module tb_wrr_burst_scheduler;

    localparam int N  = 4;
    localparam int WW = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_last = '0;
    logic [N-1:0]    req_ready;
    logic [N*WW-1:0] weight = 16'h1111;
    logic            out_ready = 1'b0;
    logic            out_valid;
    logic            out_last;
    logic [N-1:0]    grant;
    logic [IW-1:0]   grant_idx;
    logic            busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wrr_burst_scheduler #(.N(N), .WW(WW), .IW(IW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_ready (req_ready),
        .weight    (weight),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_last  (out_last),
        .grant     (grant),
        .grant_idx (grant_idx),
        .busy      (busy)
    );

    typedef struct {
        logic [3:0]  rv;
        logic [3:0]  rl;
        logic        ordy;
        logic [15:0] w;
        logic [3:0]  eg;
        logic [1:0]  ei;
        logic        eb;
        logic        eov;
        logic        eol;
        logic [3:0]  err;
    } vec_t;

    typedef struct {
        logic [1:0] idx;
        logic       last;
    } beat_t;

    vec_t  vecs [24];
    beat_t sb [$];
    int    blen [N];
    int    bursts_left [N];
    int    beat_cnt [N];
    logic  mid_tb = 1'b0;

    function automatic vec_t mk(input logic [3:0] rv, input logic [3:0] rl, input logic ordy,
                                input logic [15:0] w, input logic [3:0] eg, input logic [1:0] ei,
                                input logic eb, input logic eov, input logic eol, input logic [3:0] err);
        vec_t v;
        v.rv = rv; v.rl = rl; v.ordy = ordy; v.w = w;
        v.eg = eg; v.ei = ei; v.eb = eb; v.eov = eov; v.eol = eol; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    // Requesters may not drop valid mid-burst; mid is tracked from observed beats
    task automatic proto_check(input string name);
        checks++;
        if (mid_tb && !req_valid[grant_idx]) begin
            failures++;
            $display("FAIL %s protocol: req_valid[%0d] dropped mid-burst", name, grant_idx);
        end
        if (out_valid && out_ready) mid_tb = !out_last;
        if (grant == '0) mid_tb = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rstn = 1'b0;
        req_valid = 4'b1111;
        req_last = 4'b1111;
        out_ready = 1'b1;
        mid_tb = 1'b0;
        @(negedge clk);
        chk("rst grant", 32'(grant), 32'h0);
        chk("rst grant_idx", 32'(grant_idx), 32'h0);
        chk("rst busy", 32'(busy), 32'h0);
        chk("rst out_valid", 32'(out_valid), 32'h0);
        chk("rst out_last", 32'(out_last), 32'h0);
        chk("rst req_ready", 32'(req_ready), 32'h0);
        @(posedge clk); #1;
        rstn = 1'b1;
        req_valid = '0;
        req_last = '0;
    endtask

    task automatic apply_vec(input int k);
        @(posedge clk); #1;
        req_valid = vecs[k].rv;
        req_last = vecs[k].rl;
        out_ready = vecs[k].ordy;
        weight = vecs[k].w;
        @(negedge clk);
        chk($sformatf("v%0d grant", k), 32'(grant), 32'(vecs[k].eg));
        chk($sformatf("v%0d grant_idx", k), 32'(grant_idx), 32'(vecs[k].ei));
        chk($sformatf("v%0d busy", k), 32'(busy), 32'(vecs[k].eb));
        chk($sformatf("v%0d out_valid", k), 32'(out_valid), 32'(vecs[k].eov));
        chk($sformatf("v%0d out_last", k), 32'(out_last), 32'(vecs[k].eol));
        chk($sformatf("v%0d req_ready", k), 32'(req_ready), 32'(vecs[k].err));
        proto_check($sformatf("v%0d", k));
        $display("vec %0d: rv=%b rl=%b ordy=%b grant=%b ov=%b ol=%b rr=%b",
                 k, vecs[k].rv, vecs[k].rl, vecs[k].ordy, grant, out_valid, out_last, req_ready);
    endtask

    // Requesters stream bursts of blen[i] beats until bursts_left[i] runs out
    task automatic run_auto(input string tag, input int exp_cycles);
        int         cyc;
        logic [3:0] prev_g;
        beat_t      e;
        cyc = 0;
        prev_g = '0;
        out_ready = 1'b1;
        while ((sb.size() > 0) && (cyc < 200)) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                req_valid[i] = (bursts_left[i] > 0);
                req_last[i] = (bursts_left[i] > 0) && (beat_cnt[i] == blen[i] - 1);
            end
            @(negedge clk);
            cyc++;
            proto_check(tag);
            checks++;
            if ((grant != '0) && (prev_g != '0) && (grant != prev_g)) begin
                failures++;
                $display("FAIL %s idle gap: grant %b followed %b directly", tag, grant, prev_g);
            end
            prev_g = grant;
            if (out_valid && out_ready) begin
                e = sb.pop_front();
                chk($sformatf("%s beat idx", tag), 32'(grant_idx), 32'(e.idx));
                chk($sformatf("%s beat last", tag), 32'(out_last), 32'(e.last));
                $display("%s beat: cycle=%0d idx=%0d last=%b", tag, cyc, grant_idx, out_last);
            end
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    if (req_last[i]) begin
                        bursts_left[i]--;
                        beat_cnt[i] = 0;
                    end else begin
                        beat_cnt[i]++;
                    end
                end
            end
        end
        checks++;
        if (sb.size() > 0) begin
            failures++;
            $display("FAIL %s timeout: %0d beats outstanding after %0d cycles", tag, sb.size(), cyc);
            sb.delete();
        end
        chk($sformatf("%s cycles", tag), 32'(cyc), 32'(exp_cycles));
        @(posedge clk); #1;
        req_valid = '0;
        req_last = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        beat_t b;

        do_reset();

        // single requester, 3-beat burst, then rotation of ptr checked via picks
        vecs[0]  = mk(4'b0001, 4'b0000, 1'b1, 16'h1111, 4'b0000, 2'd0, 0, 0, 0, 4'b0000);
        vecs[1]  = mk(4'b0001, 4'b0000, 1'b1, 16'h1111, 4'b0001, 2'd0, 1, 1, 0, 4'b0001);
        vecs[2]  = mk(4'b0001, 4'b0000, 1'b1, 16'h1111, 4'b0001, 2'd0, 1, 1, 0, 4'b0001);
        vecs[3]  = mk(4'b0001, 4'b0001, 1'b1, 16'h1111, 4'b0001, 2'd0, 1, 1, 1, 4'b0001);
        vecs[4]  = mk(4'b0000, 4'b0000, 1'b1, 16'h1111, 4'b0000, 2'd0, 0, 0, 0, 4'b0000);
        vecs[5]  = mk(4'b0011, 4'b0011, 1'b1, 16'h1111, 4'b0000, 2'd0, 0, 0, 0, 4'b0000);
        vecs[6]  = mk(4'b0011, 4'b0011, 1'b1, 16'h1111, 4'b0010, 2'd1, 1, 1, 1, 4'b0010);
        vecs[7]  = mk(4'b0001, 4'b0001, 1'b1, 16'h1111, 4'b0000, 2'd0, 0, 0, 0, 4'b0000);
        vecs[8]  = mk(4'b0001, 4'b0001, 1'b1, 16'h1111, 4'b0001, 2'd0, 1, 1, 1, 4'b0001);
        // backpressure on req2 (weight 0 behaves as 1)
        vecs[9]  = mk(4'b0100, 4'b0000, 1'b1, 16'h1011, 4'b0000, 2'd0, 0, 0, 0, 4'b0000);
        vecs[10] = mk(4'b0100, 4'b0000, 1'b1, 16'h1011, 4'b0100, 2'd2, 1, 1, 0, 4'b0100);
        vecs[11] = mk(4'b0100, 4'b0000, 1'b0, 16'h1011, 4'b0100, 2'd2, 1, 1, 0, 4'b0000);
        vecs[12] = mk(4'b0100, 4'b0000, 1'b1, 16'h1011, 4'b0100, 2'd2, 1, 1, 0, 4'b0100);
        vecs[13] = mk(4'b0100, 4'b0000, 1'b0, 16'h1011, 4'b0100, 2'd2, 1, 1, 0, 4'b0000);
        vecs[14] = mk(4'b0100, 4'b0000, 1'b1, 16'h1011, 4'b0100, 2'd2, 1, 1, 0, 4'b0100);
        vecs[15] = mk(4'b0100, 4'b0100, 1'b0, 16'h1011, 4'b0100, 2'd2, 1, 1, 1, 4'b0000);
        vecs[16] = mk(4'b0100, 4'b0100, 1'b1, 16'h1011, 4'b0100, 2'd2, 1, 1, 1, 4'b0100);
        vecs[17] = mk(4'b0000, 4'b0000, 1'b1, 16'h1011, 4'b0000, 2'd0, 0, 0, 0, 4'b0000);
        // early release: req3 (weight 4) goes silent at the burst boundary
        vecs[18] = mk(4'b1010, 4'b1000, 1'b1, 16'h4111, 4'b0000, 2'd0, 0, 0, 0, 4'b0000);
        vecs[19] = mk(4'b1010, 4'b1000, 1'b1, 16'h4111, 4'b1000, 2'd3, 1, 1, 1, 4'b1000);
        vecs[20] = mk(4'b0010, 4'b0010, 1'b1, 16'h4111, 4'b1000, 2'd3, 1, 0, 0, 4'b1000);
        vecs[21] = mk(4'b0010, 4'b0010, 1'b1, 16'h4111, 4'b0000, 2'd0, 0, 0, 0, 4'b0000);
        vecs[22] = mk(4'b0010, 4'b0010, 1'b1, 16'h4111, 4'b0010, 2'd1, 1, 1, 1, 4'b0010);
        vecs[23] = mk(4'b0000, 4'b0000, 1'b1, 16'h4111, 4'b0000, 2'd0, 0, 0, 0, 4'b0000);

        for (int k = 0; k < 24; k++) begin
            apply_vec(k);
        end

        // weighting: req0 weight 3, req1 weight 1, 2-beat bursts; scan starts at ptr=2
        weight = 16'h0013;
        for (int i = 0; i < N; i++) begin
            blen[i] = 2;
            bursts_left[i] = 0;
            beat_cnt[i] = 0;
        end
        bursts_left[0] = 6;
        bursts_left[1] = 2;
        for (int rep = 0; rep < 2; rep++) begin
            for (int j = 0; j < 6; j++) begin
                b.idx = 2'd0; b.last = (j % 2 == 1); sb.push_back(b);
            end
            for (int j = 0; j < 2; j++) begin
                b.idx = 2'd1; b.last = (j == 1); sb.push_back(b);
            end
        end
        run_auto("weight", 20);

        // rotation from ptr=0, all weights 1, 1-beat bursts
        do_reset();
        weight = 16'h1111;
        for (int i = 0; i < N; i++) begin
            blen[i] = 1;
            bursts_left[i] = 2;
            beat_cnt[i] = 0;
        end
        for (int rep = 0; rep < 2; rep++) begin
            for (int i = 0; i < N; i++) begin
                b.idx = 2'(i); b.last = 1'b1; sb.push_back(b);
            end
        end
        run_auto("rotate", 16);

        // reset on beat 2 of a 5-beat burst from req2
        do_reset();
        weight = 16'h1111;
        out_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 4'b0100; req_last = 4'b0000;
        @(negedge clk);
        chk("mrst idle grant", 32'(grant), 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mrst beat1 grant", 32'(grant), 32'h4);
        chk("mrst beat1 out_valid", 32'(out_valid), 32'h1);
        $display("mrst: beat1 grant=%b", grant);
        @(posedge clk); #1;
        rstn = 1'b0;
        mid_tb = 1'b0;
        @(negedge clk);
        chk("mrst grant", 32'(grant), 32'h0);
        chk("mrst grant_idx", 32'(grant_idx), 32'h0);
        chk("mrst busy", 32'(busy), 32'h0);
        chk("mrst out_valid", 32'(out_valid), 32'h0);
        chk("mrst req_ready", 32'(req_ready), 32'h0);
        $display("mrst: in reset grant=%b busy=%b", grant, busy);
        @(posedge clk); #1;
        rstn = 1'b1;
        req_valid = 4'b1010; req_last = 4'b1010;
        @(negedge clk);
        chk("mrst post grant", 32'(grant), 32'h0);
        chk("mrst post out_valid", 32'(out_valid), 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mrst regrant grant", 32'(grant), 32'h2);
        chk("mrst regrant grant_idx", 32'(grant_idx), 32'h1);
        chk("mrst regrant out_last", 32'(out_last), 32'h1);
        $display("mrst: regrant grant=%b idx=%0d", grant, grant_idx);
        @(posedge clk); #1;
        req_valid = '0; req_last = '0;
        @(negedge clk);
        chk("mrst final grant", 32'(grant), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
